// File: rtl/turn_ctrl_pkg.sv
// Shared types and defaults for the turn-signal request controller.
//   state_t     : controller FSM states
//   req_t       : decoded request from the debounced switches
//   decode_req  : priority resolution hazard > conflict > left > right
//   req_state   : operating state selected by a request (NONE -> IDLE)
package turn_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, TURN_L, TURN_R, HAZARD, LOCKOUT} state_t;
  typedef enum logic [1:0] {NONE, L, R, HAZ} req_t;

  localparam int unsigned DEF_DEB_CYCLES = 4;
  localparam int unsigned DEF_SEQ_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT    = 64;

  function automatic req_t decode_req(input logic d_l, input logic d_r, input logic d_h);
    if (d_h)             return HAZ;
    else if (d_l && d_r) return NONE;
    else if (d_l)        return L;
    else if (d_r)        return R;
    return NONE;
  endfunction

  function automatic state_t req_state(input req_t r);
    case (r)
      L:       return TURN_L;
      R:       return TURN_R;
      HAZ:     return HAZARD;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/turn_debounce.sv
// Single-input debouncer.
//   clk, reset : clock, synchronous active-high reset
//   raw        : raw switch level
//   deb        : debounced level; follows raw after DEB_CYCLES consecutive
//                cycles of disagreement
module turn_debounce
  import turn_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (raw != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) deb_d = raw;
      else                              cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/turn_signal_ctrl.sv
// Request controller in front of the tail-light sequencer.
//   clk, reset          : clock, synchronous active-high reset
//   stalk_l/stalk_r     : raw turn-stalk levels
//   hazard_sw           : raw hazard-switch level
//   left/right/sign     : registered mode requests to the sequencer
//   busy                : controller not idle
//   timeout_flag        : sticky turn-timeout indicator, cleared on stalk release
// Modes change only at the end of a sequencer pattern so no pattern is cut short.
module turn_signal_ctrl
  import turn_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned SEQ_CYCLES = DEF_SEQ_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic stalk_l,
  input  logic stalk_r,
  input  logic hazard_sw,
  output logic left,
  output logic right,
  output logic sign,
  output logic busy,
  output logic timeout_flag
);

  localparam int unsigned PW = (SEQ_CYCLES > 1) ? $clog2(SEQ_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic d_l, d_r, d_h;

  turn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (.clk(clk), .reset(reset), .raw(stalk_l),   .deb(d_l));
  turn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (.clk(clk), .reset(reset), .raw(stalk_r),   .deb(d_r));
  turn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_h (.clk(clk), .reset(reset), .raw(hazard_sw), .deb(d_h));

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          flag_q, flag_d;
  logic          left_q, left_d, right_q, right_d, sign_q, sign_d, busy_q, busy_d;

  req_t req;
  logic boundary;
  logic same_turn;

  always_comb begin
    req       = decode_req(d_l, d_r, d_h);
    boundary  = (phase_q == PW'(SEQ_CYCLES - 1));
    same_turn = (req == L && state_q == TURN_L) || (req == R && state_q == TURN_R);
    state_d   = state_q;
    flag_d    = flag_q;

    // Release of both stalks clears the sticky flag; a timeout can only
    // fire while one stalk is held, so the set below never collides.
    if (!d_l && !d_r) flag_d = 1'b0;

    case (state_q)
      IDLE: state_d = req_state(req);
      TURN_L, TURN_R: begin
        if (boundary) begin
          if (req == HAZ) begin
            state_d = HAZARD;
          end else if (same_turn && timer_q >= TW'(TIMEOUT - 1)) begin
            state_d = LOCKOUT;
            flag_d  = 1'b1;
          end else begin
            state_d = req_state(req);
          end
        end
      end
      HAZARD: if (boundary) state_d = req_state(req);
      LOCKOUT: begin
        if (!d_l && !d_r)              state_d = IDLE;
        else if (boundary && req == HAZ) state_d = HAZARD;
      end
      default: state_d = IDLE;
    endcase

    // Phase restarts when leaving IDLE; otherwise it free-runs and wraps,
    // so mode changes (taken at the wrap) land on phase 0 automatically.
    if (state_d == IDLE || state_q == IDLE) phase_d = '0;
    else if (boundary)                      phase_d = '0;
    else                                    phase_d = phase_q + 1'b1;

    if (state_d != state_q)                           timer_d = '0;
    else if (state_q == TURN_L || state_q == TURN_R)  timer_d = timer_q + 1'b1;
    else                                              timer_d = '0;

    left_d  = (state_d == TURN_L);
    right_d = (state_d == TURN_R);
    sign_d  = (state_d == HAZARD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      timer_q <= '0;
      flag_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      flag_q  <= flag_d;
      left_q  <= left_d;
      right_q <= right_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
    end
  end

  assign left         = left_q;
  assign right        = right_q;
  assign sign         = sign_q;
  assign busy         = busy_q;
  assign timeout_flag = flag_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
module tb_turn_signal_ctrl;

  localparam int DEB = 4;
  localparam int SEQ = 4;
  localparam int TO  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stalk_l = 1'b0, stalk_r = 1'b0, hazard_sw = 1'b0;
  logic left, right, sign, busy, timeout_flag;

  always #5 clk = ~clk;

  turn_signal_ctrl #(.DEB_CYCLES(DEB), .SEQ_CYCLES(SEQ), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .stalk_l(stalk_l), .stalk_r(stalk_r),
    .hazard_sw(hazard_sw), .left(left), .right(right), .sign(sign),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Modes: 0 idle, 1 left, 2 right, 3 hazard, 4 lockout.
  // age = cycles since the controller last left idle (pattern position is age mod SEQ),
  // tage = cycles spent in the current turn mode.
  bit deb[3];
  int run[3];
  int mode, age, tage;
  bit flag;
  bit model_on = 0;

  always @(posedge clk) begin : model
    bit raw[3];
    int req, nm;
    bit bnd;
    raw[0] = stalk_l; raw[1] = stalk_r; raw[2] = hazard_sw;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin deb[i] = 0; run[i] = 0; end
      mode = 0; age = 0; tage = 0; flag = 0;
    end else begin
      if (deb[2])               req = 3;
      else if (deb[0] && deb[1]) req = 0;
      else if (deb[0])          req = 1;
      else if (deb[1])          req = 2;
      else                      req = 0;
      bnd = (age % SEQ) == SEQ - 1;
      nm = mode;
      if (!deb[0] && !deb[1]) flag = 0;
      if (mode == 0) nm = req;
      else if (mode == 1 || mode == 2) begin
        if (bnd) begin
          if (req == 3) nm = 3;
          else if (req == mode && tage >= TO - 1) begin nm = 4; flag = 1; end
          else nm = req;
        end
      end else if (mode == 3) begin
        if (bnd) nm = req;
      end else begin
        if (!deb[0] && !deb[1]) nm = 0;
        else if (bnd && req == 3) nm = 3;
      end
      age  = (nm == 0 || mode == 0) ? 0 : age + 1;
      tage = (nm != mode) ? 0 : ((nm == 1 || nm == 2) ? tage + 1 : 0);
      mode = nm;
      for (int i = 0; i < 3; i++) begin
        if (raw[i] != deb[i]) begin
          run[i]++;
          if (run[i] == DEB) begin deb[i] = raw[i]; run[i] = 0; end
        end else run[i] = 0;
      end
    end
    model_on = 1;
  end

  always @(negedge clk) begin
    if (model_on)
      check("outputs{l,r,s,busy,flag}",
            int'({left, right, sign, busy, timeout_flag}),
            int'({mode == 1, mode == 2, mode == 3, mode != 0, flag}));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_raw(input logic l, input logic r, input logic h);
    stalk_l = l; stalk_r = r; hazard_sw = h;
  endtask

  initial begin
    int cnt;
    int waited;

    // Reset held with every raw input high
    set_raw(1, 1, 1);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("reset_outputs", int'({left, right, sign, busy, timeout_flag}), 0);
    end
    reset = 0;
    cyc(DEB);
    check("post_reset_debounce", int'({left, sign, busy}), 0);
    set_raw(0, 0, 0);
    cyc(20);
    check("post_reset_idle", int'(busy), 0);

    // Glitch of 3 cycles is rejected
    stalk_l = 1;
    cyc(3);
    stalk_l = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("glitch_left", int'(left), 0);
    end

    // Stable press: left at edge 5
    stalk_l = 1;
    cyc(4);
    check("latency_left_e4", int'(left), 0);
    cyc(1);
    check("latency_left_e5", int'({left, busy}), 3);

    // Release at phase 1: pattern completes, then idle
    cyc(1);
    stalk_l = 0;
    cyc(6);
    check("boundary_hold_left", int'(left), 1);
    cyc(1);
    check("boundary_release", int'({left, busy}), 0);
    cyc(4);

    // Hazard raised during a right turn waits for the boundary
    stalk_r = 1;
    cyc(5);
    check("right_on", int'(right), 1);
    hazard_sw = 1;
    cyc(7);
    check("right_until_boundary", int'({right, sign}), 2);
    cyc(1);
    check("hazard_takes_over", int'({right, sign}), 1);
    set_raw(0, 0, 0);
    cyc(20);
    check("idle_after_hazard", int'(busy), 0);

    // Both stalks: conflict keeps idle
    set_raw(1, 1, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      check("conflict_idle", int'({left, right, sign, busy}), 0);
    end
    set_raw(0, 0, 0);
    cyc(8);

    // Turn timeout
    stalk_r = 1;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1);
      if (right) cnt++;
    end
    check("timeout_right_cycles", cnt, TO);
    check("lockout_state", int'({right, busy, timeout_flag}), 3);
    stalk_r = 0;
    waited = 0;
    while (timeout_flag && waited < 20) begin
      cyc(1);
      waited++;
    end
    check("lockout_release_cycles", waited, DEB + 1);
    check("lockout_release_idle", int'({busy, timeout_flag}), 0);
    cyc(4);

    // Reset during hazard at phase 2
    hazard_sw = 1;
    cyc(5);
    check("hazard_on", int'(sign), 1);
    cyc(2);
    reset = 1;
    cyc(1);
    check("mid_reset", int'({sign, busy}), 0);
    reset = 0;
    cyc(DEB);
    check("mid_reset_redebounce", int'(sign), 0);
    cyc(1);
    check("mid_reset_resume", int'(sign), 1);
    hazard_sw = 0;
    cyc(20);

    // Randomised traffic, checked cycle by cycle against the model
    for (int seg = 0; seg < 300; seg++) begin
      int r, dur;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        reset = 1;
        cyc($urandom_range(1, 2));
        reset = 0;
      end
      set_raw(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 3) == 0));
      r = $urandom_range(0, 99);
      if (r < 70)      dur = $urandom_range(1, 8);
      else if (r < 95) dur = $urandom_range(8, 20);
      else             dur = $urandom_range(70, 90);
      cyc(dur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
